// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Stall, flush and forwarding controller for an in-order pipeline with
// NS = NFWD+2 stages (index 0 = IF, 1 = ID, 2.. = downstream stages).
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   dbg_en, dbg_step      : debug halt request, single-step strobe (edge used)
//   rs_addr, rt_addr      : ID-stage source register addresses
//   rs_used, rt_used      : ID-stage source-used flags
//   is_store              : ID instruction is a store (rt is store data)
//   ds_wen/ds_addr/ds_load: per downstream slice k (stage k+2) write enable,
//                           destination address and "is load"
//   rom_stall             : instruction fetch not ready
//   ram_req, ram_ack      : data-memory request (stage NS-2) and completion
//   jump_en               : taken branch/jump resolved in ID
//   stage_en, stage_rst   : per-stage enable and synchronous clear
//   fwd_a_sel, fwd_b_sel  : 0 = register file, k = downstream slice k-1
//   fwd_m                 : late store-data forward from the slice-0 load
//   mem_timeout           : sticky data-memory timeout flag
//   stall_cnt             : saturating count of stalled, non-halted cycles
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int NFWD     = 3,
    parameter int AW       = 5,
    parameter int LOAD_FWD = 1,
    parameter int TIMEOUT  = 255,
    localparam int NS      = NFWD + 2,
    localparam int SW      = $clog2(NFWD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_en,
    input  logic              dbg_step,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              is_store,
    input  logic [NFWD-1:0]   ds_wen,
    input  logic [NFWD*AW-1:0] ds_addr,
    input  logic [NFWD-1:0]   ds_load,
    input  logic              rom_stall,
    input  logic              ram_req,
    input  logic              ram_ack,
    input  logic              jump_en,
    output logic [NS-1:0]     stage_en,
    output logic [NS-1:0]     stage_rst,
    output logic [SW-1:0]     fwd_a_sel,
    output logic [SW-1:0]     fwd_b_sel,
    output logic              fwd_m,
    output logic              mem_timeout,
    output logic [15:0]       stall_cnt
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Forwarding match per downstream slice
    // ------------------------------------------------------------------
    logic [NFWD-1:0] a_hit;
    logic [NFWD-1:0] b_hit;

    for (genvar gi = 0; gi < NFWD; gi++) begin : g_match
        logic [AW-1:0] slice_addr;
        assign slice_addr = ds_addr[gi*AW +: AW];
        // r0 is never a real destination, so it never forwards.
        assign a_hit[gi] = ds_wen[gi] && (slice_addr != '0) && (slice_addr == rs_addr);
        assign b_hit[gi] = ds_wen[gi] && (slice_addr != '0) && (slice_addr == rt_addr);
    end

    logic [SW-1:0] a_sel;
    logic [SW-1:0] b_sel;
    logic          a_load_early;   // selected slice is a load not yet forwardable
    logic          b_load_early;
    logic          b_from_slice0;

    // Scan from the farthest slice down so the nearest match wins.
    always_comb begin
        a_sel         = '0;
        b_sel         = '0;
        a_load_early  = 1'b0;
        b_load_early  = 1'b0;
        b_from_slice0 = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (a_hit[k]) begin
                a_sel        = SW'(k + 1);
                a_load_early = ds_load[k] && (k < LOAD_FWD);
            end
            if (b_hit[k]) begin
                b_sel         = SW'(k + 1);
                b_load_early  = ds_load[k] && (k < LOAD_FWD);
                b_from_slice0 = (k == 0);
            end
        end
    end

    logic a_haz;
    logic b_haz;
    logic store_fwd;
    logic load_stall;

    assign a_haz = rs_used && a_load_early;
    assign b_haz = rt_used && b_load_early;
    // Store data is only needed at the memory stage, so a store whose rt alone
    // depends on the slice-0 load can take the value late instead of stalling.
    assign store_fwd  = is_store && b_haz && b_from_slice0 && !a_haz;
    assign load_stall = a_haz || (b_haz && !store_fwd);

    // ------------------------------------------------------------------
    // Data-memory wait FSM
    // ------------------------------------------------------------------
    logic          ram_state_reg, ram_state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          mem_timeout_reg;
    logic          timeout_exit;
    logic          ram_wait;

    always_comb begin
        ram_state_next = ram_state_reg;
        wait_cnt_next  = wait_cnt_reg;
        timeout_exit   = 1'b0;
        ram_wait       = 1'b0;
        case (ram_state_reg)
            ST_IDLE: begin
                if (ram_req && !ram_ack) begin
                    ram_state_next = ST_WAIT;
                    wait_cnt_next  = '0;
                    ram_wait       = 1'b1;
                end
            end
            default: begin
                if (ram_ack) begin
                    ram_state_next = ST_IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    ram_state_next = ST_IDLE;
                    timeout_exit   = 1'b1;
                end else begin
                    ram_wait      = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Debug halt FSM with single-step edge detect
    // ------------------------------------------------------------------
    logic dbg_state_reg, dbg_state_next;
    logic step_reg;
    logic step_edge;
    logic halt_block;

    assign dbg_state_next = dbg_en ? ST_HALT : ST_RUN;
    assign step_edge      = dbg_step && !step_reg;
    assign halt_block     = (dbg_state_reg == ST_HALT) && !step_edge;

    // ------------------------------------------------------------------
    // Stall / flush priority
    // ------------------------------------------------------------------
    logic [NS-1:0] stage_en_c;
    logic [NS-1:0] stage_rst_c;
    logic          flush_pend_reg, flush_pend_next;
    logic          higher_stall;
    logic          do_flush;

    always_comb begin
        stage_en_c   = '1;
        stage_rst_c  = '0;
        higher_stall = 1'b1;
        do_flush     = 1'b0;
        if (halt_block) begin
            stage_en_c = '0;
        end else if (rom_stall) begin
            stage_en_c[1:0] = 2'b00;
            stage_rst_c[2]  = 1'b1;
        end else if (ram_wait) begin
            // Everything up to the memory stage holds; the stage after it
            // receives a bubble.
            stage_en_c[NS-2:0] = '0;
            stage_rst_c[NS-1]  = 1'b1;
        end else if (load_stall) begin
            stage_en_c[1:0] = 2'b00;
            stage_rst_c[2]  = 1'b1;
        end else begin
            higher_stall = 1'b0;
            if (jump_en || flush_pend_reg) begin
                stage_rst_c[1] = 1'b1;
                do_flush       = 1'b1;
            end
        end
    end

    // A jump seen while stalled is remembered and applied once the pipe moves.
    always_comb begin
        flush_pend_next = flush_pend_reg;
        if (higher_stall && jump_en) begin
            flush_pend_next = 1'b1;
        end else if (do_flush) begin
            flush_pend_next = 1'b0;
        end
    end

    logic [15:0] stall_cnt_reg, stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((stage_en_c != '1) && (dbg_state_reg != ST_HALT) && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_state_reg   <= ST_IDLE;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            dbg_state_reg   <= ST_RUN;
            step_reg        <= 1'b0;
            flush_pend_reg  <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            ram_state_reg   <= ram_state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_reg || timeout_exit;
            dbg_state_reg   <= dbg_state_next;
            step_reg        <= dbg_step;
            flush_pend_reg  <= flush_pend_next;
            stall_cnt_reg   <= stall_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: reset forces every stage clear/enabled and forwarding off
    // ------------------------------------------------------------------
    assign stage_en    = rst_n ? stage_en_c  : '1;
    assign stage_rst   = rst_n ? stage_rst_c : '1;
    assign fwd_a_sel   = rst_n ? a_sel : '0;
    assign fwd_b_sel   = rst_n ? b_sel : '0;
    assign fwd_m       = rst_n && store_fwd;
    assign mem_timeout = mem_timeout_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Directed bench for pipe_stall_ctrl (NFWD=3, AW=5, LOAD_FWD=1, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_en, dbg_step;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used, is_store;
    logic [2:0]  ds_wen;
    logic [14:0] ds_addr;
    logic [2:0]  ds_load;
    logic        rom_stall, ram_req, ram_ack, jump_en;
    logic [4:0]  stage_en, stage_rst;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        fwd_m, mem_timeout;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stall_ctrl #(
        .NFWD(3), .AW(5), .LOAD_FWD(1), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_en(dbg_en), .dbg_step(dbg_step),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used), .is_store(is_store),
        .ds_wen(ds_wen), .ds_addr(ds_addr), .ds_load(ds_load),
        .rom_stall(rom_stall), .ram_req(ram_req), .ram_ack(ram_ack),
        .jump_en(jump_en),
        .stage_en(stage_en), .stage_rst(stage_rst),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_m(fwd_m),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dbg_en = 0; dbg_step = 0;
        rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0; is_store = 0;
        ds_wen = 0; ds_addr = 0; ds_load = 0;
        rom_stall = 0; ram_req = 0; ram_ack = 0; jump_en = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        // Forwarding match present during reset must stay hidden.
        ds_wen = 3'b001; ds_addr = {5'd0, 5'd0, 5'd5}; rs_addr = 5'd5;
        tick(); tick();
        settle();
        chk("rst_stage_en",  16'(stage_en),  16'h1F);
        chk("rst_stage_rst", 16'(stage_rst), 16'h1F);
        chk("rst_fwd_a",     16'(fwd_a_sel), 16'h0);
        chk("rst_stall_cnt", stall_cnt,      16'h0);
        chk("rst_timeout",   16'(mem_timeout), 16'h0);
        tick();
        clear_inputs();
        rst_n = 1;
        settle();
        chk("idle_stage_en",  16'(stage_en),  16'h1F);
        chk("idle_stage_rst", 16'(stage_rst), 16'h00);
        tick();

        // Nearest writer wins: slices 0 and 2 both write r5.
        ds_wen = 3'b101; ds_addr = {5'd5, 5'd9, 5'd5}; rs_addr = 5'd5; rs_used = 1;
        settle();
        chk("fwd_nearest",     16'(fwd_a_sel), 16'd1);
        chk("fwd_nearest_en",  16'(stage_en),  16'h1F);
        tick();
        ds_wen = 3'b100;
        settle();
        chk("fwd_slice2", 16'(fwd_a_sel), 16'd3);
        tick();
        ds_wen = 3'b001; ds_addr = {5'd0, 5'd0, 5'd0}; rs_addr = 5'd0;
        settle();
        chk("fwd_r0_ignored", 16'(fwd_a_sel), 16'd0);
        tick();
        ds_wen = 3'b010; ds_addr = {5'd0, 5'd9, 5'd0}; rs_addr = 5'd1; rt_addr = 5'd9;
        settle();
        chk("fwd_b_slice1", 16'(fwd_b_sel), 16'd2);
        chk("fwd_a_nomatch", 16'(fwd_a_sel), 16'd0);
        tick();

        // Load-use: slice-0 load to r7 feeding rs.
        clear_inputs();
        ds_wen = 3'b001; ds_addr = {5'd0, 5'd0, 5'd7}; ds_load = 3'b001;
        rs_addr = 5'd7; rs_used = 1;
        settle();
        chk("lu_stage_en",  16'(stage_en),  16'h1C);
        chk("lu_stage_rst", 16'(stage_rst), 16'h04);
        tick();
        ds_wen = 3'b010; ds_addr = {5'd0, 5'd7, 5'd0}; ds_load = 3'b010;
        settle();
        chk("lu_after_en",  16'(stage_en),  16'h1F);
        chk("lu_after_fwd", 16'(fwd_a_sel), 16'd2);
        tick();
        // Store whose rt alone depends on the slice-0 load.
        ds_wen = 3'b001; ds_addr = {5'd0, 5'd0, 5'd7}; ds_load = 3'b001;
        rs_addr = 5'd3; rs_used = 1; rt_addr = 5'd7; rt_used = 1; is_store = 1;
        settle();
        chk("st_fwd_m",  16'(fwd_m),     16'd1);
        chk("st_no_stall", 16'(stage_en), 16'h1F);
        chk("st_fwd_b",  16'(fwd_b_sel), 16'd1);
        tick();
        is_store = 0;
        settle();
        chk("nonst_fwd_m", 16'(fwd_m),    16'd0);
        chk("nonst_stall", 16'(stage_en), 16'h1C);
        tick();
        clear_inputs();
        settle();
        chk("lu_stall_cnt", stall_cnt, 16'd2);
        tick();

        // RAM wait with ack after 4 cycles; start from a clean counter.
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        ram_req = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("ram_wait_en_c%0d", i), 16'(stage_en), 16'h10);
            chk($sformatf("ram_wait_rst_c%0d", i), 16'(stage_rst), 16'h10);
            tick();
        end
        ram_ack = 1;
        settle();
        chk("ram_ack_en", 16'(stage_en), 16'h1F);
        tick();
        ram_req = 0; ram_ack = 0;
        settle();
        chk("ram_stall_cnt", stall_cnt, 16'd4);
        tick();

        // RAM wait with no ack: timeout after 8 cycles.
        ram_req = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("to_wait_en_c%0d", i), 16'(stage_en), 16'h10);
            tick();
        end
        settle();
        chk("to_release_en", 16'(stage_en), 16'h1F);
        chk("to_flag_before", 16'(mem_timeout), 16'd0);
        tick();
        ram_req = 0;
        settle();
        chk("to_flag_set", 16'(mem_timeout), 16'd1);
        chk("to_stall_cnt", stall_cnt, 16'd12);
        tick(); tick(); tick();
        settle();
        chk("to_flag_sticky", 16'(mem_timeout), 16'd1);
        tick();

        // Jump during rom_stall is deferred to the first free cycle.
        rom_stall = 1; jump_en = 1;
        settle();
        chk("jmp_rom_en",  16'(stage_en),  16'h1C);
        chk("jmp_rom_rst", 16'(stage_rst), 16'h04);
        tick();
        jump_en = 0;
        settle();
        chk("jmp_rom_rst2", 16'(stage_rst), 16'h04);
        tick();
        rom_stall = 0;
        settle();
        chk("jmp_flush_rst", 16'(stage_rst), 16'h02);
        chk("jmp_flush_en",  16'(stage_en),  16'h1F);
        tick();
        settle();
        chk("jmp_flush_once", 16'(stage_rst), 16'h00);
        tick();
        jump_en = 1;
        settle();
        chk("jmp_direct", 16'(stage_rst), 16'h02);
        tick();
        jump_en = 0;
        settle();
        chk("jmp_direct_clr", 16'(stage_rst), 16'h00);
        chk("jmp_stall_cnt", stall_cnt, 16'd14);
        tick();

        // Debug halt and single stepping.
        dbg_en = 1;
        settle();
        chk("dbg_pre_halt_en", 16'(stage_en), 16'h1F);
        tick();
        settle();
        chk("dbg_halt_en", 16'(stage_en), 16'h00);
        tick();
        dbg_step = 1;
        settle();
        chk("dbg_step1_en", 16'(stage_en), 16'h1F);
        tick();
        settle();
        chk("dbg_step1_held", 16'(stage_en), 16'h00);
        tick();
        dbg_step = 0;
        settle();
        chk("dbg_step_low", 16'(stage_en), 16'h00);
        tick();
        dbg_step = 1;
        settle();
        chk("dbg_step2_en", 16'(stage_en), 16'h1F);
        tick();
        dbg_step = 0;
        settle();
        chk("dbg_halt_cnt", stall_cnt, 16'd14);
        dbg_en = 0;
        tick();
        settle();
        chk("dbg_run_en", 16'(stage_en), 16'h1F);
        tick();

        // rom_stall outranks ram_wait.
        ram_req = 1; rom_stall = 1;
        settle();
        chk("prio_rom_en", 16'(stage_en), 16'h1C);
        tick();
        rom_stall = 0; ram_ack = 1;
        settle();
        chk("prio_ack_en", 16'(stage_en), 16'h1F);
        tick();
        ram_ack = 0;
        ram_req = 1;
        tick();
        tick();
        // Reset in the middle of a wait abandons the access.
        rst_n = 0;
        settle();
        chk("midrst_cnt",     stall_cnt,         16'd0);
        chk("midrst_timeout", 16'(mem_timeout),  16'd0);
        chk("midrst_rst",     16'(stage_rst),    16'h1F);
        ram_req = 0;
        tick();
        rst_n = 1;
        settle();
        chk("midrst_idle_en",  16'(stage_en),  16'h1F);
        chk("midrst_idle_rst", 16'(stage_rst), 16'h00);
        tick();
        ram_req = 1; ram_ack = 1;
        settle();
        chk("req_ack_same", 16'(stage_en), 16'h1F);
        tick();
        clear_inputs();
        tick();
        settle();
        chk("final_timeout", 16'(mem_timeout), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
